rng_wb_sampler: RTL and testbench
=================================

# rng_wb_sampler

Wishbone classic initiator that drives the chaotic-scroll RNG register block from the other end of its bus. On `start` it programs seeds, scroll limits and enables, then loops: waits a programmable gap, pulses the sample strobe, reads back the three captured state words and pushes them into a small FIFO. The FIFO feeds a valid/ready stream toward downstream consumers such as an entropy packer or a test harness.

## Interface
Parameters:
- `BASE_ADDR`, 32'h3000_0000, base address of the RNG register block.
- `FIFO_DEPTH`, 4, output FIFO entries; must be a power of 2 and ≥ 4.
- `TIMEOUT`, 255, maximum cycles waiting for `wbm_ack_i` before abort.

Ports:
- `wb_clk_i`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high, on `wb_clk_i`.
- `start`  in  1  single-cycle pulse; starts the sequence; honored only in IDLE.
- `stop`  in  1  single-cycle pulse; finish the current triple, then return to IDLE.
- `x_seed`, `y_seed`, `z_seed`  in  32 each  values written to offsets 0x04 / 0x08 / 0x0C.
- `scroll_cfg`  in  24  written to 0x10, zero-extended.
- `en_cfg`  in  4  written to 0x14, zero-extended.
- `gap`  in  16  idle cycles between samples; 0 means back-to-back.
- `busy`  out  1  high whenever not in IDLE.
- `err`  out  1  sticky bus timeout flag; cleared by `rst` or `start`.
- `sample_cnt`  out  16  completed triples, wraps modulo 2^16.
- `wbm_cyc_o`, `wbm_stb_o`, `wbm_we_o`  out  1 each  Wishbone master controls.
- `wbm_sel_o`  out  4  always 4'hF while `stb` is high.
- `wbm_adr_o`, `wbm_dat_o`  out  32 each  address = `BASE_ADDR` + offset; write data.
- `wbm_dat_i`  in  32  read data, valid with ack.
- `wbm_ack_i`  in  1  responder ack.
- `m_valid`, `m_ready`  out/in  1 each  stream handshake.
- `m_data`  out  32  sample word.
- `m_tag`  out  2  0 = x, 1 = y, 2 = z.

## Operation
- States: IDLE, CFG, GAP, SMP, RD, ABORT.
- IDLE → CFG on `start`. `start` clears `err` and the FIFO.
- CFG: five writes, in order, to 0x04, 0x08, 0x0C, 0x10, 0x14. Inputs are sampled on the cycle each write is issued. Then → GAP.
- GAP: a 16-bit counter counts `gap` cycles. Leaves GAP only when the FIFO has ≥ 3 free entries; the counter stops at terminal while waiting.
- SMP: one write of 32'h1 to 0x18. Then → RD.
- RD: three reads, at 0x1C, 0x20, 0x24. Each ack pushes `{tag, wbm_dat_i}` into the FIFO. After the third read, `sample_cnt` increments. Then → IDLE if `stop` is pending, else → GAP.
- `stop` is latched in any non-IDLE state. In CFG it takes effect after CFG completes, and no sample is taken.
- Bus rule: at most one transaction outstanding.
  - `cyc` and `stb` rise together and are held until ack.
  - After ack, they drop for at least one cycle.
  - Ack is considered only while `stb` is high. Acks arriving while `stb` is low are ignored. This covers the responder's echo ack one cycle after `stb` falls.
- Timeout: a per-transaction counter starts at `stb` assertion. Reaching `TIMEOUT` without ack: drop `cyc`/`stb`, set `err`, go ABORT. ABORT goes to IDLE on the next cycle. The FIFO is kept, and a partial triple stays in it.
- FIFO: push and pop in the same cycle are allowed, including when full or empty. `m_valid` = not empty. `m_data`/`m_tag` show the head entry and hold stable while `m_valid && !m_ready`.

## Timing
- Registered outputs. Reset values: `busy` 0, `err` 0, `sample_cnt` 0, `cyc`/`stb`/`we` 0, `wbm_adr_o` 0, `wbm_dat_o` 0, `m_valid` 0, FIFO empty.
- With a 1-cycle-latency responder, each transaction takes 3 cycles: `stb` in cycle n, ack in n+1, `stb` low in n+2, next `stb` in n+3.
- `start` to first `stb`: 1 cycle. CFG total: 15 cycles.
- Read ack to `m_valid`: 1 cycle, when the FIFO was empty.
- A triple, measured from SMP `stb` to the third read ack, takes 11 cycles.
- `rst` mid-transaction: `cyc`/`stb` are low on the next edge; state goes to IDLE and the FIFO clears.

## Structure
- Package `rng_wb_pkg`:
  - register offsets `OFF_X_INIT` … `OFF_Z_DATA`;
  - the state enum;
  - the tag encoding.
- Sub-module `rng_sample_fifo`: synchronous FIFO, 34-bit width, `FIFO_DEPTH` entries. Exposes `full`, `empty` and `free_cnt`.

## Test plan
- Reset, then idle 10 cycles → all outputs hold their reset values; no `cyc`.
- `start` with `x_seed`=DE78D681, `scroll_cfg`=4D4C4B, `en_cfg`=3, 1-cycle responder → writes observed at 0x04/0x08/0x0C/0x10/0x14 with the given data, 3 cycles apart. Echo acks are ignored.
- Responder model returns x/y/z = 11111111/22222222/33333333, `m_ready`=1, `gap`=0 → stream emits tags 0,1,2 with those values; `sample_cnt` increments per triple.
- `m_ready`=0 with `FIFO_DEPTH`=4 → exactly one triple is buffered, then the block stalls in GAP with no SMP write. Raising `m_ready` resumes sampling.
- Responder never acks the 0x1C read, `TIMEOUT`=255 → `cyc` drops 255 cycles after `stb`, `err`=1, `busy`=0, no spurious push.
- `rst` asserted during a CFG write, and `stop` asserted during RD → bus idle next cycle with the FIFO empty; the current triple completes, then the block returns to IDLE.

Source files
------------

// File: rtl/rng_wb_pkg.sv
// Shared definitions for the RNG Wishbone sampler.
// Contents:
//   - register offsets of the chaotic-scroll RNG block, relative to its base
//   - sampler state encoding
//   - stream tag encoding (which state word a FIFO entry carries)
//   - helpers mapping a transaction index to its offset / tag
package rng_wb_pkg;

    localparam logic [31:0] OFF_X_INIT = 32'h0000_0004;
    localparam logic [31:0] OFF_Y_INIT = 32'h0000_0008;
    localparam logic [31:0] OFF_Z_INIT = 32'h0000_000C;
    localparam logic [31:0] OFF_SCROLL = 32'h0000_0010;
    localparam logic [31:0] OFF_ENABLE = 32'h0000_0014;
    localparam logic [31:0] OFF_SAMPLE = 32'h0000_0018;
    localparam logic [31:0] OFF_X_DATA = 32'h0000_001C;
    localparam logic [31:0] OFF_Y_DATA = 32'h0000_0020;
    localparam logic [31:0] OFF_Z_DATA = 32'h0000_0024;

    // FIFO entry: {tag, data}
    localparam int FIFO_W = 34;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG,
        ST_GAP,
        ST_SMP,
        ST_RD,
        ST_ABORT
    } state_t;

    typedef enum logic [1:0] {
        TAG_X = 2'd0,
        TAG_Y = 2'd1,
        TAG_Z = 2'd2
    } tag_t;

    // Offset of the n-th configuration write (0..4).
    function automatic logic [31:0] cfg_offset(input logic [2:0] idx);
        case (idx)
            3'd0:    return OFF_X_INIT;
            3'd1:    return OFF_Y_INIT;
            3'd2:    return OFF_Z_INIT;
            3'd3:    return OFF_SCROLL;
            default: return OFF_ENABLE;
        endcase
    endfunction

    // Offset of the n-th state-word read (0..2).
    function automatic logic [31:0] rd_offset(input logic [1:0] idx);
        case (idx)
            2'd0:    return OFF_X_DATA;
            2'd1:    return OFF_Y_DATA;
            default: return OFF_Z_DATA;
        endcase
    endfunction

    function automatic tag_t idx_to_tag(input logic [1:0] idx);
        case (idx)
            2'd0:    return TAG_X;
            2'd1:    return TAG_Y;
            default: return TAG_Z;
        endcase
    endfunction

endpackage

// File: rtl/rng_sample_fifo.sv
// Synchronous first-word-fall-through FIFO for captured RNG state words.
// Ports:
//   wb_clk_i, rst      clock, synchronous active-high reset
//   clr                synchronous flush (same effect as rst on contents)
//   push, push_data    write side; a push while full is accepted only if a
//                      pop happens in the same cycle
//   pop                read side; ignored while empty
//   head_data          oldest entry, valid while !empty
//   full, empty        status
//   free_cnt           number of unused entries
module rng_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 34
) (
    input  logic                       wb_clk_i,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     free_cnt
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             push_en;
    logic             pop_en;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == (AW+1)'(DEPTH));
    assign free_cnt  = (AW+1)'(DEPTH) - count_reg;
    assign pop_en    = pop && !empty;
    // A pop frees the slot the same cycle, so a full FIFO can still accept.
    assign push_en   = push && (!full || pop_en);
    assign head_data = mem[rd_ptr_reg];

    always_ff @(posedge wb_clk_i) begin
        if (push_en) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (rst || clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({push_en, pop_en})
                2'b10:   count_reg <= count_reg + (AW+1)'(1);
                2'b01:   count_reg <= count_reg - (AW+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/rng_wb_sampler.sv
// Wishbone classic initiator that configures the chaotic-scroll RNG block,
// then repeatedly strobes a sample and reads back the x/y/z state words
// into a FIFO feeding a valid/ready stream.
// Ports:
//   wb_clk_i, rst                 clock, synchronous active-high reset
//   start, stop                   single-cycle control pulses
//   x_seed, y_seed, z_seed        seed values (sampled when each write issues)
//   scroll_cfg, en_cfg            scroll limits / enables (zero-extended)
//   gap                           idle cycles between samples
//   busy, err, sample_cnt         status
//   wbm_*                         Wishbone classic master
//   m_valid, m_ready, m_data, m_tag   output stream (tag 0=x, 1=y, 2=z)
module rng_wb_sampler
    import rng_wb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          TIMEOUT    = 255
) (
    input  logic        wb_clk_i,
    input  logic        rst,
    input  logic        start,
    input  logic        stop,
    input  logic [31:0] x_seed,
    input  logic [31:0] y_seed,
    input  logic [31:0] z_seed,
    input  logic [23:0] scroll_cfg,
    input  logic [3:0]  en_cfg,
    input  logic [15:0] gap,
    output logic        busy,
    output logic        err,
    output logic [15:0] sample_cnt,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [31:0] m_data,
    output logic [1:0]  m_tag
);

    localparam int FCW  = $clog2(FIFO_DEPTH) + 1;
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic              stb_reg, stb_next;
    logic              we_reg, we_next;
    logic [31:0]       adr_reg, adr_next;
    logic [31:0]       dat_reg, dat_next;
    logic [2:0]        idx_reg, idx_next;
    logic [15:0]       gap_cnt_reg, gap_cnt_next;
    logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
    logic              stop_pend_reg, stop_pend_next;
    logic              err_reg, err_next;
    logic              busy_reg, busy_next;
    logic [15:0]       sample_cnt_reg, sample_cnt_next;

    logic              issue;
    logic              issue_we;
    logic [31:0]       issue_off;
    logic [31:0]       issue_dat;
    logic              ack_seen;
    logic              stop_now;
    logic [31:0]       cfg_word;

    logic              fifo_push;
    logic              fifo_clr;
    logic [FIFO_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [FCW-1:0]    fifo_free;

    // Acks are qualified by our own strobe so the responder's echo ack,
    // arriving in the cycle after the strobe drops, is never counted.
    assign ack_seen = stb_reg && wbm_ack_i;
    assign stop_now = stop_pend_reg || stop;

    always_comb begin
        case (idx_reg)
            3'd0:    cfg_word = x_seed;
            3'd1:    cfg_word = y_seed;
            3'd2:    cfg_word = z_seed;
            3'd3:    cfg_word = {8'h00, scroll_cfg};
            default: cfg_word = {28'h0, en_cfg};
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        stb_next        = stb_reg;
        we_next         = we_reg;
        adr_next        = adr_reg;
        dat_next        = dat_reg;
        idx_next        = idx_reg;
        gap_cnt_next    = gap_cnt_reg;
        to_cnt_next     = to_cnt_reg;
        err_next        = err_reg;
        sample_cnt_next = sample_cnt_reg;
        fifo_push       = 1'b0;
        fifo_clr        = 1'b0;
        issue           = 1'b0;
        issue_we        = 1'b0;
        issue_off       = '0;
        issue_dat       = '0;

        // A stop request is remembered until the sequencer is back in IDLE.
        stop_pend_next = (state_reg != ST_IDLE) && stop_now;

        if (stb_reg) begin
            to_cnt_next = to_cnt_reg + TO_W'(1);
        end

        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    err_next   = 1'b0;
                    fifo_clr   = 1'b1;
                    idx_next   = 3'd0;
                    state_next = ST_CFG;
                    issue      = 1'b1;
                    issue_we   = 1'b1;
                    issue_off  = OFF_X_INIT;
                    issue_dat  = x_seed;
                end
            end

            ST_CFG: begin
                if (!stb_reg) begin
                    issue     = 1'b1;
                    issue_we  = 1'b1;
                    issue_off = cfg_offset(idx_reg);
                    issue_dat = cfg_word;
                end else if (ack_seen) begin
                    stb_next = 1'b0;
                    if (idx_reg == 3'd4) begin
                        gap_cnt_next = '0;
                        state_next   = stop_now ? ST_IDLE : ST_GAP;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end

            ST_GAP: begin
                // The counter parks at its terminal value while waiting for
                // room for a whole triple in the FIFO.
                if (stop_now) begin
                    state_next = ST_IDLE;
                end else if (gap_cnt_reg < gap) begin
                    gap_cnt_next = gap_cnt_reg + 16'd1;
                end else if (fifo_free >= FCW'(3)) begin
                    state_next = ST_SMP;
                    issue      = 1'b1;
                    issue_we   = 1'b1;
                    issue_off  = OFF_SAMPLE;
                    issue_dat  = 32'h0000_0001;
                end
            end

            ST_SMP: begin
                if (ack_seen) begin
                    stb_next   = 1'b0;
                    idx_next   = 3'd0;
                    state_next = ST_RD;
                end
            end

            ST_RD: begin
                if (!stb_reg) begin
                    issue     = 1'b1;
                    issue_off = rd_offset(idx_reg[1:0]);
                end else if (ack_seen) begin
                    stb_next  = 1'b0;
                    fifo_push = 1'b1;
                    if (idx_reg == 3'd2) begin
                        sample_cnt_next = sample_cnt_reg + 16'd1;
                        gap_cnt_next    = '0;
                        state_next      = stop_now ? ST_IDLE : ST_GAP;
                    end else begin
                        idx_next = idx_reg + 3'd1;
                    end
                end
            end

            ST_ABORT: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Bus timeout: abandon the transaction, keep whatever the FIFO holds.
        if (stb_reg && !wbm_ack_i && (to_cnt_reg == TO_LAST)) begin
            stb_next   = 1'b0;
            err_next   = 1'b1;
            state_next = ST_ABORT;
        end

        if (issue) begin
            stb_next    = 1'b1;
            we_next     = issue_we;
            adr_next    = BASE_ADDR + issue_off;
            dat_next    = issue_dat;
            to_cnt_next = '0;
        end

        busy_next = (state_next != ST_IDLE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            stb_reg        <= 1'b0;
            we_reg         <= 1'b0;
            adr_reg        <= '0;
            dat_reg        <= '0;
            idx_reg        <= '0;
            gap_cnt_reg    <= '0;
            to_cnt_reg     <= '0;
            stop_pend_reg  <= 1'b0;
            err_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            sample_cnt_reg <= '0;
        end else begin
            state_reg      <= state_next;
            stb_reg        <= stb_next;
            we_reg         <= we_next;
            adr_reg        <= adr_next;
            dat_reg        <= dat_next;
            idx_reg        <= idx_next;
            gap_cnt_reg    <= gap_cnt_next;
            to_cnt_reg     <= to_cnt_next;
            stop_pend_reg  <= stop_pend_next;
            err_reg        <= err_next;
            busy_reg       <= busy_next;
            sample_cnt_reg <= sample_cnt_next;
        end
    end

    rng_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .wb_clk_i  (wb_clk_i),
        .rst       (rst),
        .clr       (fifo_clr),
        .push      (fifo_push),
        .push_data ({idx_to_tag(idx_reg[1:0]), wbm_dat_i}),
        .pop       (m_ready),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .free_cnt  (fifo_free)
    );

    assign busy       = busy_reg;
    assign err        = err_reg;
    assign sample_cnt = sample_cnt_reg;
    assign wbm_cyc_o  = stb_reg;
    assign wbm_stb_o  = stb_reg;
    assign wbm_we_o   = we_reg;
    assign wbm_sel_o  = stb_reg ? 4'hF : 4'h0;
    assign wbm_adr_o  = adr_reg;
    assign wbm_dat_o  = dat_reg;
    assign m_valid    = !fifo_empty;
    assign m_data     = fifo_head[31:0];
    assign m_tag      = fifo_head[33:32];

endmodule

// File: tb/tb_rng_wb_sampler.sv
`timescale 1ns/1ps
module tb_rng_wb_sampler;
    import rng_wb_pkg::*;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        wb_clk_i = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] x_seed = 32'hDE78_D681;
    logic [31:0] y_seed = 32'h1357_9BDF;
    logic [31:0] z_seed = 32'h2468_ACE0;
    logic [23:0] scroll_cfg = 24'h4D4C4B;
    logic [3:0]  en_cfg = 4'h3;
    logic [15:0] gap = 16'd0;
    logic        busy, err;
    logic [15:0] sample_cnt;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = 32'h0;
    logic        wbm_ack_i = 1'b0;
    logic        m_valid;
    logic        m_ready = 1'b1;
    logic [31:0] m_data;
    logic [1:0]  m_tag;

    rng_wb_sampler #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (4),
        .TIMEOUT    (255)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .x_seed     (x_seed),
        .y_seed     (y_seed),
        .z_seed     (z_seed),
        .scroll_cfg (scroll_cfg),
        .en_cfg     (en_cfg),
        .gap        (gap),
        .busy       (busy),
        .err        (err),
        .sample_cnt (sample_cnt),
        .wbm_cyc_o  (wbm_cyc_o),
        .wbm_stb_o  (wbm_stb_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_adr_o  (wbm_adr_o),
        .wbm_dat_o  (wbm_dat_o),
        .wbm_dat_i  (wbm_dat_i),
        .wbm_ack_i  (wbm_ack_i),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_tag      (m_tag)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int checks = 0;
    int errors = 0;
    int cyc_count = 0;
    always @(posedge wb_clk_i) cyc_count <= cyc_count + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    // 1-cycle responder; keeps acking while stb stays high, which produces the
    // echo ack one cycle after the master drops stb.
    logic noack_x = 1'b0;
    always @(posedge wb_clk_i) begin
        wbm_ack_i <= wbm_cyc_o && wbm_stb_o && !rst &&
                     !(noack_x && (wbm_adr_o == BASE + OFF_X_DATA));
        case (wbm_adr_o - BASE)
            OFF_X_DATA: wbm_dat_i <= 32'h1111_1111;
            OFF_Y_DATA: wbm_dat_i <= 32'h2222_2222;
            OFF_Z_DATA: wbm_dat_i <= 32'h3333_3333;
            default:    wbm_dat_i <= 32'hDEAD_BEEF;
        endcase
    end

    // Scoreboards
    typedef struct packed {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
    } bus_t;
    bus_t        exp_bus[$];
    logic [33:0] exp_strm[$];

    task automatic exp_write(input logic [31:0] off, input logic [31:0] dat);
        bus_t b;
        b.we = 1'b1; b.adr = BASE + off; b.dat = dat;
        exp_bus.push_back(b);
    endtask

    task automatic exp_read(input logic [31:0] off);
        bus_t b;
        b.we = 1'b0; b.adr = BASE + off; b.dat = '0;
        exp_bus.push_back(b);
    endtask

    task automatic exp_cfg();
        exp_write(OFF_X_INIT, x_seed);
        exp_write(OFF_Y_INIT, y_seed);
        exp_write(OFF_Z_INIT, z_seed);
        exp_write(OFF_SCROLL, {8'h00, scroll_cfg});
        exp_write(OFF_ENABLE, {28'h0, en_cfg});
    endtask

    task automatic exp_triple(input logic with_stream);
        exp_write(OFF_SAMPLE, 32'h1);
        exp_read(OFF_X_DATA);
        exp_read(OFF_Y_DATA);
        exp_read(OFF_Z_DATA);
        if (with_stream) begin
            exp_strm.push_back({2'd0, 32'h1111_1111});
            exp_strm.push_back({2'd1, 32'h2222_2222});
            exp_strm.push_back({2'd2, 32'h3333_3333});
        end
    endtask

    // Bus monitor: compares every new strobe with the expected transaction list
    // and measures strobe timing.
    logic prev_stb = 1'b0;
    int   rise_cyc = 0;
    int   prev_rise = -1;
    int   last_smp = -1;
    int   last_dur = 0;
    int   start_cyc = 0;
    logic chk_period = 1'b0;
    always @(negedge wb_clk_i) begin
        bus_t e;
        if (wbm_stb_o && !prev_stb) begin
            if (exp_bus.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL bus_unexpected: got adr %h we %b, required no transaction",
                         wbm_adr_o, wbm_we_o);
            end else begin
                e = exp_bus.pop_front();
                check("bus_adr", wbm_adr_o, e.adr);
                check("bus_we", wbm_we_o, e.we);
                if (e.we) check("bus_dat", wbm_dat_o, e.dat);
                check("bus_sel_cyc", {wbm_sel_o, wbm_cyc_o}, {4'hF, 1'b1});
            end
            if (wbm_adr_o == BASE + OFF_X_INIT) begin
                check("start_to_stb", cyc_count - start_cyc, 1);
                last_smp = -1;
            end else if (wbm_adr_o >= BASE + OFF_Y_INIT && wbm_adr_o <= BASE + OFF_ENABLE) begin
                check("cfg_spacing", cyc_count - prev_rise, 3);
            end else if (wbm_adr_o == BASE + OFF_SAMPLE) begin
                if (chk_period && last_smp >= 0) check("smp_period", cyc_count - last_smp, 12);
                last_smp = cyc_count;
            end
            rise_cyc = cyc_count;
            prev_rise = cyc_count;
        end
        if (!wbm_stb_o && prev_stb) last_dur = cyc_count - rise_cyc;
        prev_stb = wbm_stb_o;
    end

    // Stream monitor: each handshake pops one expected word.
    always @(negedge wb_clk_i) begin
        logic [33:0] e;
        if (!rst && m_valid && m_ready) begin
            if (exp_strm.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL strm_unexpected: got tag %0d data %h, required no word", m_tag, m_data);
            end else begin
                e = exp_strm.pop_front();
                check("strm_tag", m_tag, e[33:32]);
                check("strm_data", m_data, e[31:0]);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge wb_clk_i);
            #1;
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        start_cyc = cyc_count;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int bound);
        int n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        check(nm, busy, 0);
    endtask

    task automatic wait_cnt(input string nm, input logic [15:0] k, input int bound);
        int n = 0;
        while (sample_cnt != k && n < bound) begin
            tick();
            n++;
        end
        check(nm, sample_cnt, k);
    endtask

    task automatic wait_stb(input string nm, input logic [31:0] off, input int bound);
        int n = 0;
        while (!(wbm_stb_o && wbm_adr_o == BASE + off) && n < bound) begin
            tick();
            n++;
        end
        check(nm, {wbm_stb_o, wbm_adr_o}, {1'b1, BASE + off});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset and idle
        tick(3);
        rst = 1'b0;
        tick(10);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_sample_cnt", sample_cnt, 0);
        check("rst_cyc_stb_we", {wbm_cyc_o, wbm_stb_o, wbm_we_o}, 3'b000);
        check("rst_adr", wbm_adr_o, 0);
        check("rst_dat", wbm_dat_o, 0);
        check("rst_m_valid", m_valid, 0);

        // Configure, then free-running sampling with gap 0; stop during RD
        exp_cfg();
        repeat (3) exp_triple(1'b1);
        chk_period = 1'b1;
        do_start();
        check("run_busy", busy, 1);
        wait_cnt("run_cnt2", 16'd2, 200);
        wait_stb("run_rd_x", OFF_X_DATA, 50);
        pulse_stop();
        wait_idle("run_stop_idle", 50);
        chk_period = 1'b0;
        check("run_cnt3", sample_cnt, 3);
        check("run_err", err, 0);
        tick(5);
        check("run_drained", m_valid, 0);

        // Backpressure: one triple buffered, then stall in GAP
        m_ready = 1'b0;
        exp_cfg();
        exp_triple(1'b1);
        do_start();
        tick(80);
        check("bp_busy", busy, 1);
        check("bp_cnt", sample_cnt, 4);
        check("bp_head", {m_valid, m_tag, m_data}, {1'b1, 2'd0, 32'h1111_1111});
        tick(10);
        check("bp_head_stable", {m_valid, m_tag, m_data}, {1'b1, 2'd0, 32'h1111_1111});
        exp_triple(1'b1);
        m_ready = 1'b1;
        wait_stb("bp_resume_smp", OFF_SAMPLE, 30);
        pulse_stop();
        wait_idle("bp_stop_idle", 50);
        check("bp_cnt_final", sample_cnt, 5);

        // Timeout on the x read
        tick(5);
        noack_x = 1'b1;
        exp_cfg();
        exp_write(OFF_SAMPLE, 32'h1);
        exp_read(OFF_X_DATA);
        do_start();
        wait_stb("to_rd_x", OFF_X_DATA, 60);
        begin
            int n = 0;
            while (wbm_stb_o && n < 300) begin
                tick();
                n++;
            end
        end
        check("to_cyc_low", wbm_cyc_o, 0);
        check("to_err", err, 1);
        tick();
        check("to_dur", last_dur, 255);
        check("to_busy", busy, 0);
        check("to_no_push", m_valid, 0);
        check("to_cnt", sample_cnt, 5);
        noack_x = 1'b0;

        // start clears err; rst clears a stalled FIFO
        m_ready = 1'b0;
        exp_cfg();
        exp_triple(1'b0);
        do_start();
        check("start_clr_err", err, 0);
        tick(60);
        check("stall_valid", m_valid, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_fifo_empty", m_valid, 0);
        check("rst_cnt_clr", sample_cnt, 0);

        // rst during a CFG write
        exp_write(OFF_X_INIT, x_seed);
        exp_write(OFF_Y_INIT, y_seed);
        do_start();
        wait_stb("cfg_wr_y", OFF_Y_INIT, 10);
        rst = 1'b1;
        tick();
        check("rst_mid_bus", {wbm_cyc_o, wbm_stb_o}, 2'b00);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_valid", m_valid, 0);
        rst = 1'b0;
        tick(5);
        check("rst_mid_stay_idle", {wbm_cyc_o, busy}, 2'b00);

        tick(3);
        check("bus_queue_drained", exp_bus.size(), 0);
        check("strm_queue_drained", exp_strm.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
